// File: rtl/des_key_sched_if.sv
// Subkey handshake bundle between the DES key schedule (slave) and the round datapath (master).
interface des_key_sched_if;
  logic [63:0] i_key;
  logic        i_decrypt;
  logic        i_load;
  logic        i_key_ready;
  logic        o_key_valid;
  logic [47:0] o_subkey;
  logic [3:0]  o_round;
  logic        o_last;
  logic        o_busy;

  modport slave (
    input  i_key, i_decrypt, i_load, i_key_ready,
    output o_key_valid, o_subkey, o_round, o_last, o_busy
  );

  modport master (
    output i_key, i_decrypt, i_load, i_key_ready,
    input  o_key_valid, o_subkey, o_round, o_last, o_busy
  );
endinterface

// File: rtl/des_key_sched.sv
// Iterative DES key schedule: one 48-bit round subkey per handshake, encrypt (K1..K16)
// or decrypt (K16..K1) order, with C/D rotated in place between rounds.
module des_key_sched (
  input  logic           i_clk,
  input  logic           i_rst,
  des_key_sched_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  // Tables in DES bit numbering (bit 1 = MSB).
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic [55:0] pc1_key;
  logic [55:0] cd;
  logic [47:0] subkey;

  // Shift schedule indexed 0..15 (S[1]..S[16]).
  function automatic logic [1:0] shift_amt(input logic [3:0] idx);
    return (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  always_comb begin
    pc1_key = '0;
    for (int unsigned i = 0; i < 56; i++)
      pc1_key[6'(55 - i)] = bus.i_key[6'(64 - PC1[i])];
  end

  assign cd = {c_q, d_q};

  always_comb begin
    subkey = '0;
    for (int unsigned i = 0; i < 48; i++)
      subkey[6'(47 - i)] = cd[6'(56 - PC2[i])];
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (bus.i_load) begin
          state_d = RUN;
          round_d = '0;
          dec_d   = bus.i_decrypt;
          if (bus.i_decrypt) begin
            c_d = pc1_key[55:28];
            d_d = pc1_key[27:0];
          end else begin
            c_d = rotl(pc1_key[55:28], 2'd1);
            d_d = rotl(pc1_key[27:0], 2'd1);
          end
        end
      end
      RUN: begin
        if (bus.i_key_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
          end else begin
            round_d = round_q + 4'd1;
            // Decrypt undoes S[16-round]; ~round_q is the 0-based index 15-round.
            if (dec_q) begin
              c_d = rotr(c_q, shift_amt(~round_q));
              d_d = rotr(d_q, shift_amt(~round_q));
            end else begin
              c_d = rotl(c_q, shift_amt(round_q + 4'd1));
              d_d = rotl(d_q, shift_amt(round_q + 4'd1));
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.o_key_valid = (state_q == RUN);
  assign bus.o_subkey    = subkey;
  assign bus.o_round     = round_q;
  assign bus.o_last      = (state_q == RUN) && (round_q == 4'd15);
  assign bus.o_busy      = (state_q != IDLE);
endmodule
